// File: rtl/color_region_pkg.sv
// Shared definitions for the color region controller.
// Holds the PS/2 set-2 scan codes the block reacts to, the controller state
// enumeration, and a helper that maps digit scan codes to values.
package color_region_pkg;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_C     = 8'h21;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Returns {is_digit, value[3:0]}; value is 0 when not a digit key.
  function automatic logic [4:0] digit_of(input logic [7:0] code);
    case (code)
      8'h45:   return {1'b1, 4'd0};
      8'h16:   return {1'b1, 4'd1};
      8'h1E:   return {1'b1, 4'd2};
      8'h26:   return {1'b1, 4'd3};
      8'h25:   return {1'b1, 4'd4};
      8'h2E:   return {1'b1, 4'd5};
      8'h36:   return {1'b1, 4'd6};
      8'h3D:   return {1'b1, 4'd7};
      8'h3E:   return {1'b1, 4'd8};
      8'h46:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/region_decode.sv
// Maps a pixel coordinate to a region index along one axis without a divider.
// index = largest c with count >= c*SPAN, clamped to N-1.
//   count : pixel column or line
//   index : region column or row
module region_decode #(
  parameter int N    = 4,
  parameter int SPAN = 160,
  localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic [9:0]    count,
  output logic [IW-1:0] index
);

  // Boundaries are constants, so this is a bank of compares plus a priority pick.
  always_comb begin
    index = '0;
    for (int c = 1; c < N; c++) begin
      if (int'(count) >= c * SPAN) index = IW'(c);
    end
  end

endmodule

// File: rtl/color_region_ctrl.sv
// Keyboard-driven region color editor with a 2-stage pixel lookup.
// A COLS x ROWS grid of color registers is edited via PS/2 make codes
// (cursor moves, digit writes, increment, clear sweep). The pixel path maps
// (h_cnt,v_cnt) to a region and returns its color two cycles later, inverting
// the cursor region during the on-phase of the blink.
//   clk, rst            : clock, async active-high reset
//   key_valid/code/break: scan code strobe
//   h_cnt, v_cnt        : current pixel position
//   frame_tick          : once per frame, drives the blink
//   color_id/pixel_valid: pixel result, 2-cycle latency
//   cursor              : selected region index (row-major)
//   busy                : clear sweep in progress
module color_region_ctrl
  import color_region_pkg::*;
#(
  parameter int COLS         = 4,
  parameter int ROWS         = 4,
  parameter int COLOR_W      = 4,
  parameter int H_ACT        = 640,
  parameter int V_ACT        = 480,
  parameter int BLINK_FRAMES = 30,
  localparam int NREG        = COLS * ROWS,
  localparam int CUR_W       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  input  logic               key_break,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  input  logic               frame_tick,
  output logic [COLOR_W-1:0] color_id,
  output logic               pixel_valid,
  output logic [CUR_W-1:0]   cursor,
  output logic               busy
);

  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW     = $clog2(BLINK_FRAMES + 1);
  localparam int CMAX_I = (1 << COLOR_W) - 1;

  state_e                          state_q;
  logic                            busy_q;
  logic [CUR_W-1:0]                clr_q;
  logic [CW-1:0]                   cur_col_q;
  logic [RW-1:0]                   cur_row_q;
  logic [NREG-1:0][COLOR_W-1:0]    regs_q;
  logic                            key_vld_q;
  logic [7:0]                      key_code_q;
  logic [BW-1:0]                   blink_cnt_q;
  logic                            blink_q;
  logic [CW-1:0]                   s1_col_q;
  logic [RW-1:0]                   s1_row_q;
  logic [1:0]                      vld_pipe;
  logic [COLOR_W-1:0]              color_q;

  logic [CUR_W-1:0]   cur_idx;
  logic [4:0]         dig;
  logic [COLOR_W-1:0] dig_val;

  assign cur_idx = CUR_W'(cur_row_q) * CUR_W'(COLS) + CUR_W'(cur_col_q);
  assign dig     = digit_of(key_code_q);
  assign dig_val = (int'(dig[3:0]) > CMAX_I) ? COLOR_W'(CMAX_I) : COLOR_W'(dig[3:0]);

  // Make events are latched here and acted on one cycle later by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_vld_q  <= 1'b0;
      key_code_q <= '0;
    end else begin
      key_vld_q  <= key_valid & ~key_break;
      key_code_q <= key_code;
    end
  end

  // Controller: cursor, region store writes and the clear sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      clr_q     <= '0;
      cur_col_q <= '0;
      cur_row_q <= '0;
      regs_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_vld_q) begin
            if (dig[4]) begin
              regs_q[cur_idx] <= dig_val;
            end else begin
              case (key_code_q)
                SC_W: cur_row_q <= (cur_row_q == '0) ? RW'(ROWS - 1) : cur_row_q - RW'(1);
                SC_S: cur_row_q <= (cur_row_q == RW'(ROWS - 1)) ? '0 : cur_row_q + RW'(1);
                SC_A: cur_col_q <= (cur_col_q == '0) ? CW'(COLS - 1) : cur_col_q - CW'(1);
                SC_D: cur_col_q <= (cur_col_q == CW'(COLS - 1)) ? '0 : cur_col_q + CW'(1);
                SC_SPACE: regs_q[cur_idx] <= regs_q[cur_idx] + COLOR_W'(1);
                SC_C: begin
                  state_q <= ST_CLEAR;
                  busy_q  <= 1'b1;
                  clr_q   <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        ST_CLEAR: begin
          // Keys arriving now are dropped: the latched event is simply not consumed.
          regs_q[clr_q] <= '0;
          clr_q         <= clr_q + CUR_W'(1);
          if (clr_q == CUR_W'(NREG - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Blink: phase toggles every BLINK_FRAMES frame ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  // Pixel path stage 1: region decode.
  logic [CW-1:0] dec_col;
  logic [RW-1:0] dec_row;
  logic          act;

  region_decode #(.N(COLS), .SPAN(H_ACT / COLS)) u_col_dec (.count(h_cnt), .index(dec_col));
  region_decode #(.N(ROWS), .SPAN(V_ACT / ROWS)) u_row_dec (.count(v_cnt), .index(dec_row));

  assign act = (int'(h_cnt) < H_ACT) && (int'(v_cnt) < V_ACT);

  // Stage 2: read the registered store, invert the cursor region when blinking.
  logic [CUR_W-1:0]   s1_idx;
  logic [COLOR_W-1:0] rd_color;

  assign s1_idx   = CUR_W'(s1_row_q) * CUR_W'(COLS) + CUR_W'(s1_col_q);
  assign rd_color = regs_q[s1_idx] ^ {COLOR_W{(s1_idx == cur_idx) && blink_q}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_col_q <= '0;
      s1_row_q <= '0;
      vld_pipe <= '0;
      color_q  <= '0;
    end else begin
      s1_col_q <= dec_col;
      s1_row_q <= dec_row;
      vld_pipe <= {vld_pipe[0], act};
      color_q  <= vld_pipe[0] ? rd_color : '0;
    end
  end

  assign color_id    = color_q;
  assign pixel_valid = vld_pipe[1];
  assign cursor      = cur_idx;
  assign busy        = busy_q;

endmodule

// File: tb/tb_color_region_ctrl.sv
// Randomized bench for color_region_ctrl with an in-bench reference model.
// Two instances share stimulus: COLOR_W=4 and COLOR_W=3 (digit clamp case).
module tb_color_region_ctrl;

  logic       clk, rst;
  logic       key_valid, key_break, frame_tick;
  logic [7:0] key_code;
  logic [9:0] h_cnt, v_cnt;
  logic [3:0] color_a, cursor_a, cursor_b;
  logic [2:0] color_b;
  logic       pv_a, pv_b, busy_a, busy_b;

  color_region_ctrl #(.COLS(4), .ROWS(4), .COLOR_W(4), .BLINK_FRAMES(2)) u_dut_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_break(key_break),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_tick(frame_tick),
    .color_id(color_a), .pixel_valid(pv_a), .cursor(cursor_a), .busy(busy_a));

  color_region_ctrl #(.COLS(4), .ROWS(4), .COLOR_W(3), .BLINK_FRAMES(2)) u_dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_break(key_break),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_tick(frame_tick),
    .color_id(color_b), .pixel_valid(pv_b), .cursor(cursor_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] dcodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  int  mask [2] = '{15, 7};
  int  m_reg [2][16];
  int  m_cur, m_clr, m_bcnt, s1_reg;
  bit  m_busy, m_pend, m_ph, s1_act;
  logic [7:0] m_pcode;
  int  e_col [2];
  bit  e_pv;

  task automatic model_key(input logic [7:0] c);
    int row, col;
    row = m_cur / 4;
    col = m_cur % 4;
    for (int d = 0; d < 10; d++)
      if (c == dcodes[d])
        for (int w = 0; w < 2; w++) m_reg[w][m_cur] = (d > mask[w]) ? mask[w] : d;
    case (c)
      8'h1D: row = (row + 3) % 4;
      8'h1B: row = (row + 1) % 4;
      8'h1C: col = (col + 3) % 4;
      8'h23: col = (col + 1) % 4;
      8'h29: for (int w = 0; w < 2; w++) m_reg[w][m_cur] = (m_reg[w][m_cur] + 1) & mask[w];
      8'h21: begin m_busy = 1; m_clr = 0; end
      default: ;
    endcase
    m_cur = row * 4 + col;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < 2; w++) begin
        e_col[w] = 0;
        for (int i = 0; i < 16; i++) m_reg[w][i] = 0;
      end
      m_cur = 0; m_clr = 0; m_bcnt = 0; s1_reg = 0;
      m_busy = 0; m_pend = 0; m_ph = 0; s1_act = 0; e_pv = 0; m_pcode = 0;
    end else begin
      // Output after this edge uses the pixel sampled one edge ago and pre-edge state.
      for (int w = 0; w < 2; w++) begin
        if (!s1_act) e_col[w] = 0;
        else if (s1_reg == m_cur && m_ph) e_col[w] = (~m_reg[w][s1_reg]) & mask[w];
        else e_col[w] = m_reg[w][s1_reg];
      end
      e_pv   = s1_act;
      s1_act = (h_cnt < 640) && (v_cnt < 480);
      s1_reg = ((h_cnt / 160 > 3) ? 3 : h_cnt / 160) + 4 * ((v_cnt / 120 > 3) ? 3 : v_cnt / 120);
      if (m_busy) begin
        for (int w = 0; w < 2; w++) m_reg[w][m_clr] = 0;
        if (m_clr == 15) m_busy = 0;
        else m_clr++;
      end else if (m_pend) begin
        model_key(m_pcode);
      end
      m_pend  = key_valid && !key_break;
      m_pcode = key_code;
      if (frame_tick) begin
        m_bcnt++;
        if (m_bcnt == 2) begin m_bcnt = 0; m_ph = !m_ph; end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("color_a", color_a, e_col[0]);
      chk("color_b", color_b, e_col[1]);
      chk("pv_a", pv_a, e_pv);
      chk("pv_b", pv_b, e_pv);
      chk("cursor_a", cursor_a, m_cur);
      chk("cursor_b", cursor_b, m_cur);
      chk("busy_a", busy_a, m_busy);
      chk("busy_b", busy_b, m_busy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [7:0] c, input logic brk);
    key_valid = 1; key_code = c; key_break = brk;
    @(posedge clk); #1;
    key_valid = 0; key_break = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int h, input int v);
    h_cnt = 10'(h); v_cnt = 10'(v);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic ftick();
    frame_tick = 1;
    @(posedge clk); #1;
    frame_tick = 0;
    @(posedge clk); #1;
  endtask

  logic [7:0] rcodes [16] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h21, 8'h45, 8'h16,
                              8'h3D, 8'h46, 8'h2E, 8'h29, 8'h23, 8'h1B, 8'h00, 8'h5A};

  initial begin
    int bc, waited;
    rst = 1; key_valid = 0; key_code = 0; key_break = 0;
    h_cnt = 0; v_cnt = 0; frame_tick = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_color", color_a, 0);
    chk("rst_pv", pv_a, 0);
    chk("rst_cursor", cursor_a, 0);
    chk("rst_busy", busy_a, 0);
    rst = 0;
    cmp_en = 1;

    // cursor wrap and break filtering
    repeat (5) press(8'h23, 0);
    chk("d_x5_cursor", cursor_a, 1);
    press(8'h23, 1);
    press(8'h1D, 1);
    chk("break_cursor", cursor_a, 1);
    press(8'h1C, 0);
    chk("a_cursor", cursor_a, 0);
    press(8'h1D, 0);
    chk("w_wrap_cursor", cursor_a, 12);
    press(8'h1B, 0);

    // digit write and 2-cycle pixel path
    press(8'h3D, 0);
    pixel(0, 0);
    chk("px7_a", color_a, 7);
    chk("px7_b", color_b, 7);
    chk("px7_pv", pv_a, 1);

    // region 5: digit clamp, increment wrap
    press(8'h23, 0);
    press(8'h1B, 0);
    chk("cursor5", cursor_a, 5);
    press(8'h46, 0);
    pixel(200, 150);
    chk("dig9_a", color_a, 9);
    chk("dig9_clamp_b", color_b, 7);
    repeat (6) press(8'h29, 0);
    chk("r5_15", color_a, 15);
    press(8'h29, 0);
    chk("r5_wrap0", color_a, 0);
    press(8'h25, 0);

    // clear sweep, W pressed mid-sweep must be dropped
    key_valid = 1; key_code = 8'h21;
    @(posedge clk); #1;
    key_valid = 0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin key_valid = 1; key_code = 8'h1D; end
      else key_valid = 0;
      if (busy_a) bc++;
    end
    chk("busy_cycles", bc, 16);
    chk("sweep_cursor", cursor_a, 5);
    pixel(200, 150);
    chk("clr_r5", color_a, 0);
    pixel(0, 0);
    chk("clr_r0", color_a, 0);

    // blink: cursor region 5 = 3, inverted after 2 frame ticks
    press(8'h26, 0);
    ftick();
    ftick();
    pixel(200, 150);
    chk("blink_a", color_a, 12);
    chk("blink_b", color_b, 4);
    pixel(0, 0);
    chk("blink_other", color_a, 0);
    chk("blink_other_pv", pv_a, 1);
    pixel(640, 0);
    chk("inact_color", color_a, 0);
    chk("inact_pv", pv_a, 0);

    // reset during sweep
    pixel(200, 150);
    key_valid = 1; key_code = 8'h21;
    @(posedge clk); #1;
    key_valid = 0;
    waited = 0;
    while (!busy_a && waited < 5) begin @(posedge clk); #1; waited++; end
    chk("sweep_start", busy_a, 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_color", color_a, 0);
    chk("mid_rst_pv", pv_a, 0);
    chk("mid_rst_cursor", cursor_a, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_r5", color_a, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      h_cnt      = 10'($urandom_range(0, 700));
      v_cnt      = 10'($urandom_range(0, 520));
      key_valid  = ($urandom % 4) == 0;
      key_code   = rcodes[$urandom % 16];
      key_break  = ($urandom % 5) == 0;
      frame_tick = ($urandom % 16) == 0;
      @(posedge clk); #1;
    end
    key_valid = 0; frame_tick = 0;
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
